// File: rtl/m_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// byte-enable width, statistics counter width and port-index sizing.
package m_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  // Byte enables per requester / memory port (one per byte of a 32-bit word)
  localparam int BE_W = 4;

  // Width of each statistics counter
  localparam int STAT_W = 32;

  // Bits needed to hold a port index; a single port still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_dmem_arbiter_picker.sv
// m_rr_picker: combinational round-robin picker. The pending vector is
// rotated so that port rr_ptr sits at bit 0, the lowest set bit wins, and
// the one-hot result is rotated back to real port numbering.
module m_rr_picker
  import m_dmem_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] rotated;
  logic [N_REQ-1:0] first_hot;
  logic             taken;

  // Rotate, pick the lowest set bit, rotate the winner back to its port
  always_comb begin
    rotated     = '0;
    first_hot   = '0;
    taken       = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = |i_pending;

    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j == ((i + int'(i_rr_ptr)) % N_REQ)) begin
          rotated[i] = i_pending[j];
        end
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (rotated[i] && !taken) begin
        first_hot[i] = 1'b1;
        taken        = 1'b1;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (first_hot[i] && (j == ((i + int'(i_rr_ptr)) % N_REQ))) begin
          o_grant[j]  = 1'b1;
          o_grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/m_dmem_arbiter.sv
// m_dmem_arbiter: round-robin arbiter sharing one cached-memory data port
// between N_REQ requesters. A winner is acked in ST_IDLE, its request is
// latched and driven in ST_ISSUE (held across stalls), and reads wait in
// ST_HOLD for the cache before returning data with a one-cycle rvalid.
// Optional build macro ARB_STATS_EN adds per-port grant counters and a
// memory stall-cycle counter; without it the stat ports are tied to zero.
module m_dmem_arbiter
  import m_dmem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req_ren,
  input  logic [N_REQ*BE_W-1:0]    i_req_wen,
  input  logic [N_REQ*ADDR_W-1:0]  i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_req_data,
  output logic [N_REQ-1:0]         o_req_ack,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_mem_ren,
  output logic [BE_W-1:0]          o_mem_wen,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_data,
  input  logic [DATA_W-1:0]        i_mem_data,
  input  logic                     i_mem_stall,
  output logic [N_REQ*STAT_W-1:0]  o_stat_grants,
  output logic [STAT_W-1:0]        o_stat_stall
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  own_q, own_d;
  logic              ren_q, ren_d;
  logic [BE_W-1:0]   wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;

  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [IDX_W-1:0]  rr_next;
  logic              sel_ren;
  logic [BE_W-1:0]   sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [N_REQ-1:0]  ack_c;
  logic              mem_ren_c;
  logic [BE_W-1:0]   mem_wen_c;

  // A port wants service when it reads or has any byte enable set
  always_comb begin
    pending = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pending[k] = i_req_ren[k] | (|i_req_wen[k*BE_W +: BE_W]);
    end
  end

  m_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_pending   (pending),
    .i_rr_ptr    (rr_ptr_q),
    .o_grant     (grant),
    .o_grant_idx (grant_idx),
    .o_any       (grant_any)
  );

  // Select the winning port's request fields and the pointer after it
  always_comb begin
    sel_ren  = 1'b0;
    sel_wen  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_ren  = i_req_ren[k];
        sel_wen  = i_req_wen[k*BE_W +: BE_W];
        sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
    if (grant_idx == IDX_W'(N_REQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_idx + IDX_W'(1);
    end
  end

  // Next-state and output logic of the grant / issue / hold sequence
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    own_d     = own_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    rvalid_d  = '0;
    ack_c     = '0;
    mem_ren_c = 1'b0;
    mem_wen_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          ack_c    = grant;
          own_d    = grant_idx;
          ren_d    = sel_ren & ~(|sel_wen);
          wen_d    = sel_wen;
          addr_d   = sel_addr;
          data_d   = sel_data;
          rr_ptr_d = rr_next;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_ren_c = ren_q;
        mem_wen_c = wen_q;
        if (!i_mem_stall) begin
          state_d = (|wen_q) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!i_mem_stall) begin
          rdata_d = i_mem_data;
          for (int k = 0; k < N_REQ; k++) begin
            rvalid_d[k] = (own_q == IDX_W'(k));
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers, cleared by synchronous reset
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      own_q    <= own_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // An ack during reset would be dropped, so never show one then
  assign o_req_ack  = ack_c & {N_REQ{~rst}};
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_mem_ren  = mem_ren_c;
  assign o_mem_wen  = mem_wen_c;
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [N_REQ];
  logic [STAT_W-1:0] grant_cnt_d [N_REQ];
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: grants per port and stalled memory cycles
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      grant_cnt_d[k] = grant_cnt_q[k];
      if (o_req_ack[k] && (grant_cnt_q[k] != '1)) begin
        grant_cnt_d[k] = grant_cnt_q[k] + STAT_W'(1);
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_ISSUE) || (state_q == ST_HOLD)) && i_mem_stall &&
        (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge i_clk) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        grant_cnt_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        grant_cnt_q[k] <= grant_cnt_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten the per-port grant counters onto the output bus
  always_comb begin
    o_stat_grants = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_stat_grants[k*STAT_W +: STAT_W] = grant_cnt_q[k];
    end
  end

  assign o_stat_stall = stall_cnt_q;
`else
  assign o_stat_grants = '0;
  assign o_stat_stall  = '0;
`endif

endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Self-checking bench for m_dmem_arbiter with two requesters: directed
// vector table, hand-written multi-cycle sequences (miss, fairness, reset,
// statistics) and a randomized run against a transaction-level model.
module tb_m_dmem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_ren;
  logic [N*4-1:0]  req_wen;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    o_req_ack;
  logic [N-1:0]    o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic            o_mem_ren;
  logic [3:0]      o_mem_wen;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_data;
  logic [DW-1:0]   mem_rdata;
  logic            mem_stall;
  logic [N*32-1:0] o_stat_grants;
  logic [31:0]     o_stat_stall;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  m_dmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk         (i_clk),
    .rst           (rst),
    .i_req_ren     (req_ren),
    .i_req_wen     (req_wen),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_req_ack     (o_req_ack),
    .o_rvalid      (o_rvalid),
    .o_rdata       (o_rdata),
    .o_mem_ren     (o_mem_ren),
    .o_mem_wen     (o_mem_wen),
    .o_mem_addr    (o_mem_addr),
    .o_mem_data    (o_mem_data),
    .i_mem_data    (mem_rdata),
    .i_mem_stall   (mem_stall),
    .o_stat_grants (o_stat_grants),
    .o_stat_stall  (o_stat_stall)
  );

  // Memory model: each word is a fixed scramble of its address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0F1E;
  endfunction

  assign mem_rdata = mem_word(o_mem_addr);

  typedef struct {
    logic [1:0]  ren;
    logic [7:0]  wen;
    logic [31:0] a0, a1, d0, d1;
    logic        stall;
    logic [1:0]  e_ack;
    logic        e_mren;
    logic [3:0]  e_mwen;
    logic [31:0] e_addr, e_data;
    logic [1:0]  e_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] ren, input logic [7:0] wen,
                              input logic [31:0] a0, a1, d0, d1, input logic stall,
                              input logic [1:0] e_ack, input logic e_mren,
                              input logic [3:0] e_mwen, input logic [31:0] e_addr,
                              input logic [31:0] e_data, input logic [1:0] e_rvalid,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.stall = stall; v.e_ack = e_ack; v.e_mren = e_mren; v.e_mwen = e_mwen;
    v.e_addr = e_addr; v.e_data = e_data; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] ren, input logic [7:0] wen,
                               input logic [31:0] a0, a1, d0, d1, input logic stall);
    @(posedge i_clk);
    #1;
    req_ren   = ren;
    req_wen   = wen;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    mem_stall = stall;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] e_ack, input logic e_mren,
                             input logic [3:0] e_mwen, input logic [31:0] e_addr,
                             input logic [31:0] e_data, input logic [1:0] e_rvalid,
                             input logic [31:0] e_rdata, input bit chk_rdata);
    bit ok;
    checks++;
    ok = (o_req_ack === e_ack) && (o_mem_ren === e_mren) && (o_mem_wen === e_mwen) &&
         (o_mem_addr === e_addr) && (o_mem_data === e_data) && (o_rvalid === e_rvalid) &&
         (!chk_rdata || (o_rdata === e_rdata));
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got ack=%b ren=%b wen=%h addr=%h data=%h rvalid=%b rdata=%h, want ack=%b ren=%b wen=%h addr=%h data=%h rvalid=%b rdata=%h (rdata checked=%0d)",
               name, o_req_ack, o_mem_ren, o_mem_wen, o_mem_addr, o_mem_data, o_rvalid, o_rdata,
               e_ack, e_mren, e_mwen, e_addr, e_data, e_rvalid, e_rdata, chk_rdata);
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    @(posedge i_clk);
    #1;
    rst = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_data = '0; mem_stall = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic doWrite(input int port, input int nstall);
    applyStimulus(2'b00, (port == 1) ? 8'hF0 : 8'h0F, 32'h700, 32'h704, 32'hA, 32'hB, 1'b0);
    @(negedge i_clk);
    checkValue($sformatf("stat_wr_ack_p%0d", port), 64'(o_req_ack), (port == 1) ? 64'd2 : 64'd1);
    repeat (nstall) applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b1);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
  endtask

  // Transaction-level reference model state for the randomized run
  logic        m_busy, m_done, m_ren;
  int          m_owner, m_last;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [1:0]  m_rvalid;
  logic        a_ren [N];
  logic [3:0]  a_wen [N];
  logic [31:0] a_addr [N];
  logic [31:0] a_data [N];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grants, rv, cyc, winner, acked, kind;
    logic [1:0] exp_ack, new_rv;
    logic       stall;

    rst = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_data = '0; mem_stall = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_state", 2'b00, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1);
    checkValue("reset_stats", {o_stat_grants[31:0] | o_stat_grants[63:32], o_stat_stall}, 64'h0);

    // Directed cycle table: dual read, stalled write, read, read+write as write
    vecs.push_back(mk(2'b11, 8'h00, 32'h10, 32'h20, 0, 0, 0, 2'b01, 0, 4'h0, 32'h0,  32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'h00, 32'h10, 32'h20, 0, 0, 0, 2'b00, 1, 4'h0, 32'h10, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'h00, 32'h10, 32'h20, 0, 0, 0, 2'b00, 0, 4'h0, 32'h10, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'h00, 32'h10, 32'h20, 0, 0, 0, 2'b10, 0, 4'h0, 32'h10, 32'h0, 2'b01, mem_word(32'h10)));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 4'h0, 32'h20, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, 32'h20, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, 32'h20, 32'h0, 2'b10, mem_word(32'h20)));
    vecs.push_back(mk(2'b00, 8'h03, 32'h100, 0, 32'hDEADBEEF, 0, 0, 2'b01, 0, 4'h0, 32'h20, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 4'h3, 32'h100, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 4'h3, 32'h100, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'h3, 32'h100, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'h00, 0, 32'h40, 0, 0, 0, 2'b10, 0, 4'h0, 32'h100, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 4'h0, 32'h40, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, 32'h40, 32'h0, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'hF0, 0, 32'h80, 0, 32'h12345678, 0, 2'b10, 0, 4'h0, 32'h40, 32'h0, 2'b10, mem_word(32'h40)));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'hF, 32'h80, 32'h12345678, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, 32'h80, 32'h12345678, 2'b00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ren, vecs[i].wen, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].stall);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_mren, vecs[i].e_mwen,
                  vecs[i].e_addr, vecs[i].e_data, vecs[i].e_rvalid, vecs[i].e_rdata,
                  vecs[i].e_rvalid != 2'b00);
    end

    // Read miss on port1: 17 stall cycles in the hold phase
    applyStimulus(2'b10, 8'h00, 0, 32'h240, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("miss_ack", 2'b10, 0, 4'h0, 32'h80, 32'h12345678, 2'b00, 0, 0);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("miss_issue", 2'b00, 1, 4'h0, 32'h240, 32'h0, 2'b00, 0, 0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b1);
      @(negedge i_clk);
      checkOutput($sformatf("miss_wait%0d", i), 2'b00, 0, 4'h0, 32'h240, 32'h0, 2'b00, 0, 0);
    end
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("miss_release", 2'b00, 0, 4'h0, 32'h240, 32'h0, 2'b00, 0, 0);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("miss_rvalid", 2'b00, 0, 4'h0, 32'h240, 32'h0, 2'b10, mem_word(32'h240), 1);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("miss_single_pulse", 2'b00, 0, 4'h0, 32'h240, 32'h0, 2'b00, 0, 0);

    // Both ports continuously pending: grants must alternate 0,1,0,1...
    grants = 0; rv = 0; cyc = 0;
    while (grants < 8 && cyc < 80) begin
      applyStimulus(2'b11, 8'h00, 32'h500, 32'h600, 0, 0, 1'b0);
      @(negedge i_clk);
      cyc++;
      if (o_rvalid != 2'b00) rv++;
      if (o_req_ack != 2'b00) begin
        checkValue($sformatf("alt_grant%0d", grants), 64'(o_req_ack), (grants % 2 == 0) ? 64'd1 : 64'd2);
        grants++;
      end
    end
    if (grants < 8) begin
      checks++; errors++;
      $display("[TB] FAIL alt_timeout: got %0d grants, want 8", grants);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
      @(negedge i_clk);
      if (o_rvalid != 2'b00) rv++;
    end
    checkValue("alt_rvalid_count", 64'(rv), 64'd8);

    // Reset while waiting in the hold phase: transaction abandoned
    applyStimulus(2'b01, 8'h00, 32'h300, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkValue("rsthold_ack", 64'(o_req_ack), 64'd1);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b1);
    @(negedge i_clk);
    checkOutput("rsthold_wait", 2'b00, 0, 4'h0, 32'h300, 32'h0, 2'b00, 0, 0);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b1);
    rst = 1'b1;
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rsthold_cleared", 2'b00, 0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    checkOutput("rsthold_no_rvalid", 2'b00, 0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1);
    applyStimulus(2'b11, 8'h00, 32'h310, 32'h320, 0, 0, 1'b0);
    @(negedge i_clk);
    checkValue("rsthold_tie_port0", 64'(o_req_ack), 64'd1);
    repeat (4) applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);

    // Statistics: 5 grants to port0, 3 to port1, 7 stalled cycles
    resetDut();
    doWrite(0, 2); doWrite(1, 1); doWrite(0, 1); doWrite(1, 2);
    doWrite(0, 0); doWrite(0, 1); doWrite(1, 0); doWrite(0, 0);
    applyStimulus(2'b00, 8'h00, 0, 0, 0, 0, 1'b0);
    @(negedge i_clk);
`ifdef ARB_STATS_EN
    checkValue("stat_grants", 64'(o_stat_grants), {32'd3, 32'd5});
    checkValue("stat_stall", 64'(o_stat_stall), 64'd7);
`else
    checkValue("stat_grants_tied", 64'(o_stat_grants), 64'd0);
    checkValue("stat_stall_tied", 64'(o_stat_stall), 64'd0);
`endif

    // Randomized traffic against the transaction-level model
    resetDut();
    m_busy = 0; m_done = 0; m_ren = 0; m_owner = 0; m_last = N - 1;
    m_wen = '0; m_addr = '0; m_data = '0; m_rdata = '0; m_rvalid = '0;
    for (int p = 0; p < N; p++) begin
      a_ren[p] = 0; a_wen[p] = '0; a_addr[p] = '0; a_data[p] = '0;
    end
    acked = -1;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (acked == p) begin
          a_ren[p] = 0; a_wen[p] = '0;
        end
        if (!a_ren[p] && a_wen[p] == 4'h0) begin
          if ($urandom_range(0, 2) == 0) begin
            kind = $urandom_range(0, 2);
            a_ren[p]  = (kind != 1);
            a_wen[p]  = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a_addr[p] = 32'($urandom_range(0, 255)) << 2;
            a_data[p] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          a_ren[p] = 0; a_wen[p] = '0;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      applyStimulus({a_ren[1], a_ren[0]}, {a_wen[1], a_wen[0]}, a_addr[0], a_addr[1],
                    a_data[0], a_data[1], stall);
      @(negedge i_clk);
      winner = -1;
      exp_ack = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_last + k) % N;
          if (winner < 0 && (a_ren[p] || a_wen[p] != 4'h0)) winner = p;
        end
        if (winner >= 0) exp_ack[winner] = 1'b1;
      end
      checkOutput($sformatf("rand%0d", c), exp_ack, m_busy && !m_done && m_ren,
                  (m_busy && !m_done) ? m_wen : 4'h0, m_addr, m_data, m_rvalid, m_rdata,
                  m_rvalid != 2'b00);
      new_rv = '0;
      if (winner >= 0) begin
        m_busy = 1; m_done = 0; m_owner = winner; m_last = winner;
        m_ren  = a_ren[winner] && (a_wen[winner] == 4'h0);
        m_wen  = a_wen[winner]; m_addr = a_addr[winner]; m_data = a_data[winner];
      end else if (m_busy && !m_done && !stall) begin
        if (m_wen != 4'h0) m_busy = 0;
        else m_done = 1;
      end else if (m_busy && m_done && !stall) begin
        m_busy = 0;
        new_rv[m_owner] = 1'b1;
        m_rdata = mem_word(m_addr);
      end
      m_rvalid = new_rv;
      acked = winner;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_dmem_arbiter.md
Name: m_dmem_arbiter

Overview:
- Round-robin arbiter that shares one cached-memory data port between N_REQ requesters, e.g. CPU load/store unit, instruction-fetch refill and a DMA/loader engine.
- Latches the winning request, drives it onto the memory port and holds it across memory stalls.
- Returns read data to the owner with a registered valid pulse.
- Sits directly in front of m_cached_memory's i_dmem_*/o_dmem_* interface.

Parameters:
N_REQ, 2, number of requester ports (2..8)
ADDR_W, 32, byte-address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
i_clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
i_req_ren  in  N_REQ  per-port read request
i_req_wen  in  N_REQ*4  per-port byte write enables; port k uses [4k+:4]
i_req_addr  in  N_REQ*ADDR_W  per-port address
i_req_data  in  N_REQ*DATA_W  per-port write data
o_req_ack  out  N_REQ  one-cycle pulse: request latched
o_rvalid  out  N_REQ  one-cycle pulse: o_rdata valid for that port
o_rdata  out  DATA_W  read data, shared across all ports
o_mem_ren  out  1  memory read enable
o_mem_wen  out  4  memory byte write enables
o_mem_addr  out  ADDR_W  memory address
o_mem_data  out  DATA_W  memory write data
i_mem_data  in  DATA_W  memory read data
i_mem_stall  in  1  memory stall

Behaviour:
- Reset: all outputs 0; state ST_IDLE; round-robin pointer rr_ptr = 0; latched request registers cleared.
- A port is pending when its ren is 1 or its wen is nonzero. A requester holds its request stable until it sees ack.
- A port with both wen != 0 and ren = 1 is treated as a write; no read data is returned.
- ST_IDLE:
  - Winner = first pending port scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - o_req_ack[winner] is asserted combinationally in the same cycle.
  - Latch the winner's index, ren, wen, addr and data; set rr_ptr = (winner+1) mod N_REQ; go to ST_ISSUE.
  - No pending port: stay in ST_IDLE.
- ST_ISSUE:
  - Drive o_mem_* from the latched registers.
  - i_mem_stall = 1: stay and keep driving unchanged.
  - i_mem_stall = 0 and write: go to ST_IDLE.
  - i_mem_stall = 0 and read: go to ST_HOLD.
- ST_HOLD:
  - o_mem_ren = 0, o_mem_wen = 0; o_mem_addr is still held so the cache lookup and refill install use the same line.
  - i_mem_stall = 1 (miss refill): stay.
  - i_mem_stall = 0: register o_rdata <= i_mem_data and o_rvalid[owner] <= 1 for exactly one cycle; go to ST_IDLE.
- Outside ST_ISSUE, o_mem_ren and o_mem_wen are 0. o_mem_addr and o_mem_data always reflect the latched registers.
- Latency with no stalls:
  - Ack at cycle t, memory access at t+1.
  - Read hit: rvalid at t+3.
  - Write: next grant possible at t+2.
- A port may re-request in the cycle after its ack. It is not re-granted before the current transaction completes.
- Arbitration fairness: each pending port is granted within N_REQ transactions.
- Requests that change or withdraw before ack are sampled fresh each ST_IDLE cycle; nothing is remembered.
- Reset mid-transaction: the transaction is abandoned, the next cycle shows reset values, and no rvalid is issued.
- N_REQ = 1: the arbiter degenerates to a pass-through with the same latency.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs o_stat_grants (N_REQ*32, per-port grant counters) and o_stat_stall (32, count of ST_ISSUE/ST_HOLD cycles with i_mem_stall = 1).
- The counters saturate at 2^32-1 and are cleared by rst.
- Undefined: these ports are still present but tied to 0, and no counter logic is built.

Decomposition:
- Shared package (define.v include): state encodings ST_IDLE/ST_ISSUE/ST_HOLD (2 bits), byte-enable width constant 4, port-index width function/constant for clog2(N_REQ).
- One natural sub-module, m_rr_picker: a combinational rotate-priority-rotate picker.
  - Inputs: pending vector and rr_ptr.
  - Outputs: one-hot grant and binary index.

Test Plan:
- Both ports read simultaneously after reset, with i_mem_stall = 0 throughout -> port0 acked first, then port1; rvalid[0] 3 cycles after ack[0], rvalid[1] 3 cycles after ack[1]; o_rdata matches memory model data for each address.
- Port0 writes wen=4'b0011, addr 0x100, data 0xDEADBEEF; memory asserts stall for 2 cycles in ST_ISSUE -> o_mem_wen=0011, addr 0x100, data held 3 cycles; no rvalid; next grant the cycle after.
- Read miss on port1 at addr 0x240, memory stalls 17 cycles in ST_HOLD -> o_mem_addr stays 0x240, o_mem_ren=0 during the wait; single rvalid[1] with the refilled word.
- Both ports continuously pending for 8 transactions -> grants alternate 0,1,0,1,...; no port is granted twice in a row.
- rst asserted while in ST_HOLD -> next cycle all outputs 0, no rvalid; after release, port0 wins a tie (rr_ptr = 0).
- With ARB_STATS_EN defined, run 5 grants to port0 and 3 to port1 with 7 total stall cycles -> o_stat_grants = {3,5}, o_stat_stall = 7.
